// File: rtl/decode_issue_stage.sv
// decode_issue_stage: RV32I/M decode plus ID/EX pipeline register.
// Handles the valid/ready handshake, the load-use bubble and issue blocking
// for multiply/divide latency.
//
// Local encodings:
//   ex_mem_read  : 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
//   ex_mem_write : 0 none, 1 SB, 2 SH, 3 SW
//   ex_imm_type  : 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
//   ex_alu_a_src : 0 rs1, 1 PC;  ex_alu_b_src : 0 rs2, 1 immediate
module decode_issue_stage #(
    parameter int XLEN    = 32,
    parameter int EN_M    = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_mem_read,
    output logic [1:0]      ex_mem_write,
    output logic [1:0]      ex_wb_sel,
    output logic            ex_alu_a_src,
    output logic            ex_alu_b_src,
    output logic [2:0]      ex_imm_type,
    output logic [4:0]      ex_alu_code,
    output logic [5:0]      ex_branch_flag,
    output logic            ex_wb_en,
    output logic            ex_jump,
    output logic            ex_md_op,
    output logic            ex_md_div,
    output logic            ex_illegal,
    output logic            md_busy
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASS_B = 5'd10;

    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      mem_read;
        logic [1:0]      mem_write;
        logic [1:0]      wb_sel;
        logic            alu_a_src;
        logic            alu_b_src;
        logic [2:0]      imm_type;
        logic [4:0]      alu_code;
        logic [5:0]      branch_flag;
        logic            wb_en;
        logic            jump;
        logic            md_op;
        logic            md_div;
        logic            illegal;
    } id_ex_t;

    id_ex_t           dec;
    id_ex_t           bundle_d, bundle_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] md_cnt_d, md_cnt_q;
    logic             use_rs1, use_rs2, hazard, accept;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];

    // Combinational decode of the instruction offered by IF
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch or a stale value.
        dec          = '0;
        dec.pc       = if_pc;
        dec.rs1      = if_instr[19:15];
        dec.rs2      = if_instr[24:20];
        dec.rd       = if_instr[11:7];
        dec.alu_code = ALU_ADD;
        unique case (opcode)
            OPC_OP: begin
                dec.wb_en = 1'b1;
                if (funct7 == F7_MD) begin
                    if (EN_M != 0) begin
                        dec.md_op  = 1'b1;
                        dec.md_div = funct3[2];
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end else if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        3'b000:  dec.alu_code = ALU_ADD;
                        3'b001:  dec.alu_code = ALU_SLL;
                        3'b010:  dec.alu_code = ALU_SLT;
                        3'b011:  dec.alu_code = ALU_SLTU;
                        3'b100:  dec.alu_code = ALU_XOR;
                        3'b101:  dec.alu_code = ALU_SRL;
                        3'b110:  dec.alu_code = ALU_OR;
                        default: dec.alu_code = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec.alu_code = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec.alu_code = ALU_SRA;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.wb_en      = 1'b1;
                dec.alu_b_src  = 1'b1;
                dec.imm_type   = IMM_I;
                unique case (funct3)
                    3'b000: dec.alu_code = ALU_ADD;
                    3'b010: dec.alu_code = ALU_SLT;
                    3'b011: dec.alu_code = ALU_SLTU;
                    3'b100: dec.alu_code = ALU_XOR;
                    3'b110: dec.alu_code = ALU_OR;
                    3'b111: dec.alu_code = ALU_AND;
                    3'b001: begin
                        if (funct7 == F7_BASE) dec.alu_code = ALU_SLL;
                        else                   dec.illegal  = 1'b1;
                    end
                    default: begin
                        if (funct7 == F7_BASE)     dec.alu_code = ALU_SRL;
                        else if (funct7 == F7_ALT) dec.alu_code = ALU_SRA;
                        else                       dec.illegal  = 1'b1;
                    end
                endcase
            end
            OPC_LOAD: begin
                dec.wb_en     = 1'b1;
                dec.wb_sel    = WB_MEM;
                dec.alu_b_src = 1'b1;
                dec.imm_type  = IMM_I;
                unique case (funct3)
                    3'b000:  dec.mem_read = 3'd1;
                    3'b001:  dec.mem_read = 3'd2;
                    3'b010:  dec.mem_read = 3'd3;
                    3'b100:  dec.mem_read = 3'd4;
                    3'b101:  dec.mem_read = 3'd5;
                    default: dec.illegal  = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.alu_b_src = 1'b1;
                dec.imm_type  = IMM_S;
                unique case (funct3)
                    3'b000:  dec.mem_write = 2'd1;
                    3'b001:  dec.mem_write = 2'd2;
                    3'b010:  dec.mem_write = 2'd3;
                    default: dec.illegal   = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                dec.imm_type = IMM_B;
                unique case (funct3)
                    3'b000:  dec.branch_flag = 6'b000001;
                    3'b001:  dec.branch_flag = 6'b000010;
                    3'b100:  dec.branch_flag = 6'b000100;
                    3'b101:  dec.branch_flag = 6'b001000;
                    3'b110:  dec.branch_flag = 6'b010000;
                    3'b111:  dec.branch_flag = 6'b100000;
                    default: dec.illegal     = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec.wb_en     = 1'b1;
                dec.alu_b_src = 1'b1;
                dec.imm_type  = IMM_U;
                dec.alu_code  = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                dec.wb_en     = 1'b1;
                dec.alu_a_src = 1'b1;
                dec.alu_b_src = 1'b1;
                dec.imm_type  = IMM_U;
            end
            OPC_JAL: begin
                dec.wb_en     = 1'b1;
                dec.wb_sel    = WB_PC4;
                dec.jump      = 1'b1;
                dec.alu_a_src = 1'b1;
                dec.alu_b_src = 1'b1;
                dec.imm_type  = IMM_J;
            end
            OPC_JALR: begin
                dec.wb_en     = 1'b1;
                dec.wb_sel    = WB_PC4;
                dec.jump      = 1'b1;
                dec.alu_b_src = 1'b1;
                dec.imm_type  = IMM_I;
                if (funct3 != 3'b000) dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // An illegal instruction still flows to EX but must have no side effects.
        if (dec.illegal) begin
            dec.wb_en       = 1'b0;
            dec.mem_read    = 3'd0;
            dec.mem_write   = 2'd0;
            dec.jump        = 1'b0;
            dec.branch_flag = 6'b0;
            dec.md_op       = 1'b0;
            dec.md_div      = 1'b0;
        end
    end

    // Load-use hazard check and IF-side ready
    always_comb begin
        use_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
        use_rs2 = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
        hazard  = valid_q && (bundle_q.mem_read != 3'd0) && (bundle_q.rd != 5'd0) &&
                  ((use_rs1 && (if_instr[19:15] == bundle_q.rd)) ||
                   (use_rs2 && (if_instr[24:20] == bundle_q.rd)));
        if_ready = rst_n && !flush && !hazard && !md_busy &&
                   !(valid_q && bundle_q.md_op) && (!valid_q || ex_ready);
        accept  = if_valid && if_ready;
    end

    // Next state of ID/EX register and multiply/divide block counter
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        md_cnt_d = md_cnt_q;
        if (valid_q && ex_ready && bundle_q.md_op)
            md_cnt_d = bundle_q.md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - CNT_W'(1);
        if (flush) begin
            valid_d  = 1'b0;
            md_cnt_d = '0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
        end else if (valid_q && ex_ready) begin
            valid_d  = 1'b0;
        end
    end

    // ID/EX register and md counter with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            md_cnt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy        = (md_cnt_q != '0);
    assign ex_valid       = valid_q;
    assign ex_pc          = bundle_q.pc;
    assign ex_rs1         = bundle_q.rs1;
    assign ex_rs2         = bundle_q.rs2;
    assign ex_rd          = bundle_q.rd;
    assign ex_mem_read    = bundle_q.mem_read;
    assign ex_mem_write   = bundle_q.mem_write;
    assign ex_wb_sel      = bundle_q.wb_sel;
    assign ex_alu_a_src   = bundle_q.alu_a_src;
    assign ex_alu_b_src   = bundle_q.alu_b_src;
    assign ex_imm_type    = bundle_q.imm_type;
    assign ex_alu_code    = bundle_q.alu_code;
    assign ex_branch_flag = bundle_q.branch_flag;
    assign ex_wb_en       = bundle_q.wb_en;
    assign ex_jump        = bundle_q.jump;
    assign ex_md_op       = bundle_q.md_op;
    assign ex_md_div      = bundle_q.md_div;
    assign ex_illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed testbench for decode_issue_stage: one EN_M=1 instance and one
// EN_M=0 instance sharing the same stimulus.
module tb_decode_issue_stage;

    localparam logic [4:0]  ALU_ADD       = 5'd0;
    localparam logic [4:0]  ALU_SUB       = 5'd1;
    localparam logic [2:0]  MEM_READ_WORD = 3'd3;
    localparam logic [31:0] I_ADD3  = 32'h002081B3;  // add x3,x1,x2
    localparam logic [31:0] I_ADD9  = 32'h002084B3;  // add x9,x1,x2
    localparam logic [31:0] I_LW5   = 32'h0000A283;  // lw x5,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h00028333;  // add x6,x5,x0
    localparam logic [31:0] I_MUL7  = 32'h022083B3;  // mul x7,x1,x2
    localparam logic [31:0] I_DIV8  = 32'h0220C433;  // div x8,x1,x2
    localparam logic [31:0] I_BAD   = 32'h0000007F;  // unknown opcode

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;

    logic        if_ready, ex_valid, ex_alu_a_src, ex_alu_b_src, ex_wb_en, ex_jump;
    logic        ex_md_op, ex_md_div, ex_illegal, md_busy;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_alu_code;
    logic [2:0]  ex_mem_read, ex_imm_type;
    logic [1:0]  ex_mem_write, ex_wb_sel;
    logic [5:0]  ex_branch_flag;

    logic        n_if_ready, n_ex_valid, n_ex_alu_a_src, n_ex_alu_b_src, n_ex_wb_en, n_ex_jump;
    logic        n_ex_md_op, n_ex_md_div, n_ex_illegal, n_md_busy;
    logic [31:0] n_ex_pc;
    logic [4:0]  n_ex_rs1, n_ex_rs2, n_ex_rd, n_ex_alu_code;
    logic [2:0]  n_ex_mem_read, n_ex_imm_type;
    logic [1:0]  n_ex_mem_write, n_ex_wb_sel;
    logic [5:0]  n_ex_branch_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_issue_stage #(.XLEN(32), .EN_M(1), .MUL_LAT(2), .DIV_LAT(32), .CNT_W(6)) u_dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_wb_sel(ex_wb_sel),
        .ex_alu_a_src(ex_alu_a_src), .ex_alu_b_src(ex_alu_b_src), .ex_imm_type(ex_imm_type),
        .ex_alu_code(ex_alu_code), .ex_branch_flag(ex_branch_flag), .ex_wb_en(ex_wb_en),
        .ex_jump(ex_jump), .ex_md_op(ex_md_op), .ex_md_div(ex_md_div),
        .ex_illegal(ex_illegal), .md_busy(md_busy)
    );

    decode_issue_stage #(.XLEN(32), .EN_M(0), .MUL_LAT(2), .DIV_LAT(32), .CNT_W(6)) u_dut_nom (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(n_if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(n_ex_valid), .ex_pc(n_ex_pc), .ex_rs1(n_ex_rs1), .ex_rs2(n_ex_rs2), .ex_rd(n_ex_rd),
        .ex_mem_read(n_ex_mem_read), .ex_mem_write(n_ex_mem_write), .ex_wb_sel(n_ex_wb_sel),
        .ex_alu_a_src(n_ex_alu_a_src), .ex_alu_b_src(n_ex_alu_b_src), .ex_imm_type(n_ex_imm_type),
        .ex_alu_code(n_ex_alu_code), .ex_branch_flag(n_ex_branch_flag), .ex_wb_en(n_ex_wb_en),
        .ex_jump(n_ex_jump), .ex_md_op(n_ex_md_op), .ex_md_div(n_ex_md_div),
        .ex_illegal(n_ex_illegal), .md_busy(n_md_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [76:0] all_out;
        rst_n = 1'b0; if_valid = 1'b1; if_instr = I_ADD3; if_pc = 32'h40; ex_ready = 1'b1;
        repeat (3) step();
        all_out = {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_mem_write, ex_wb_sel,
                   ex_alu_a_src, ex_alu_b_src, ex_imm_type, ex_alu_code, ex_branch_flag,
                   ex_wb_en, ex_jump, ex_md_op, ex_md_div, ex_illegal, md_busy};
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready: got %b want 0", if_ready); end
        checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        rst_n = 1'b1;
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL release_if_ready: got %b want 1", if_ready); end
        step();
        if_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", ex_valid); end
        checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL first_rd: got %0d want 3", ex_rd); end
        checks++; if (ex_wb_en !== 1'b1) begin errors++; $display("FAIL first_wb_en: got %b want 1", ex_wb_en); end
        checks++; if (ex_alu_code !== ALU_ADD) begin errors++; $display("FAIL first_alu: got %0d want %0d", ex_alu_code, ALU_ADD); end
        checks++; if (ex_pc !== 32'h40) begin errors++; $display("FAIL first_pc: got %h want 40", ex_pc); end
        step();
    endtask

    task automatic test_illegal();
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = I_MUL7;
        step();
        if_instr = I_BAD;
        checks++; if (n_ex_illegal !== 1'b1) begin errors++; $display("FAIL nom_mul_illegal: got %b want 1", n_ex_illegal); end
        checks++; if ({n_ex_wb_en, n_ex_mem_read, n_ex_mem_write, n_ex_md_op} !== 7'b0) begin errors++; $display("FAIL nom_mul_side: got %b want 0", {n_ex_wb_en, n_ex_mem_read, n_ex_mem_write, n_ex_md_op}); end
        checks++; if ({ex_illegal, ex_md_op, ex_md_div} !== 3'b010) begin errors++; $display("FAIL mul_decode: got %b want 010", {ex_illegal, ex_md_op, ex_md_div}); end
        step();
        if_valid = 1'b0;
        checks++; if (n_ex_illegal !== 1'b1) begin errors++; $display("FAIL nom_bad_illegal: got %b want 1", n_ex_illegal); end
        checks++; if ({n_ex_wb_en, n_ex_mem_read, n_ex_mem_write, n_ex_jump, n_ex_branch_flag} !== 13'b0) begin errors++; $display("FAIL nom_bad_side: got %b want 0", {n_ex_wb_en, n_ex_mem_read, n_ex_mem_write, n_ex_jump, n_ex_branch_flag}); end
        repeat (4) step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr [5] = '{32'h402081B3, 32'h00208063, 32'h0020E063, 32'h0020A063, 32'h000000EF};
        logic [4:0]  alu   [5] = '{ALU_SUB, ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD};
        logic [5:0]  flag  [5] = '{6'b000000, 6'b000001, 6'b010000, 6'b000000, 6'b000000};
        logic [2:0]  misc  [5] = '{3'b001, 3'b000, 3'b000, 3'b100, 3'b011}; // {illegal, jump, wb_en}
        ex_ready = 1'b1; if_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_instr = instr[i]; if_pc = 32'h100 + 32'(4 * i);
            step();
            checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL b2b_issue[%0d]: got v=%b pc=%h want v=1 pc=%h", i, ex_valid, ex_pc, 32'h100 + 32'(4 * i)); end
            checks++; if (ex_alu_code !== alu[i] || ex_branch_flag !== flag[i]) begin errors++; $display("FAIL b2b_decode[%0d]: got alu=%0d flag=%b want alu=%0d flag=%b", i, ex_alu_code, ex_branch_flag, alu[i], flag[i]); end
            checks++; if ({ex_illegal, ex_jump, ex_wb_en} !== misc[i]) begin errors++; $display("FAIL b2b_ctrl[%0d]: got %b want %b", i, {ex_illegal, ex_jump, ex_wb_en}, misc[i]); end
        end
        if_valid = 1'b0;
        step();
    endtask

    task automatic test_load_use();
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = I_LW5;
        step();
        if_instr = I_ADD6;
        #1;
        checks++; if (ex_mem_read !== MEM_READ_WORD || ex_rd !== 5'd5) begin errors++; $display("FAIL lu_load: got mr=%0d rd=%0d want mr=3 rd=5", ex_mem_read, ex_rd); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: got %b want 0", if_ready); end
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b want 0", ex_valid); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL lu_resume: got %b want 1", if_ready); end
        step();
        if_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin errors++; $display("FAIL lu_consumer: got v=%b rd=%0d want v=1 rd=6", ex_valid, ex_rd); end
        step();
    endtask

    task automatic test_stall();
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = I_ADD3; if_pc = 32'h200;
        step();
        if_instr = I_ADD9; if_pc = 32'h204;
        for (int i = 0; i < 4; i++) begin
            checks++; if (if_ready !== 1'b0 || ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_pc !== 32'h200) begin errors++; $display("FAIL stall_hold[%0d]: got rdy=%b v=%b rd=%0d pc=%h want 0 1 3 200", i, if_ready, ex_valid, ex_rd, ex_pc); end
            step();
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", if_ready); end
        step();
        if_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9) begin errors++; $display("FAIL stall_next: got v=%b rd=%0d want v=1 rd=9", ex_valid, ex_rd); end
        step();
    endtask

    task automatic test_md_mul();
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = I_MUL7;
        step();
        if_instr = I_ADD9;
        #1;
        checks++; if (ex_md_op !== 1'b1 || if_ready !== 1'b0) begin errors++; $display("FAIL mul_handoff: got md=%b rdy=%b want md=1 rdy=0", ex_md_op, if_ready); end
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++; if (md_busy !== 1'b1 || if_ready !== 1'b0) begin errors++; $display("FAIL mul_block[%0d]: got busy=%b rdy=%b want 1 0", i, md_busy, if_ready); end
        end
        step();
        checks++; if (md_busy !== 1'b0 || if_ready !== 1'b1) begin errors++; $display("FAIL mul_done: got busy=%b rdy=%b want 0 1", md_busy, if_ready); end
        step();
        if_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9) begin errors++; $display("FAIL mul_next: got v=%b rd=%0d want v=1 rd=9", ex_valid, ex_rd); end
        step();
    endtask

    task automatic test_md_div();
        int busy_cnt = 0;
        int ready_at = 0;
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = I_DIV8;
        step();
        if_instr = I_ADD9;
        checks++; if (ex_md_op !== 1'b1 || ex_md_div !== 1'b1 || ex_rd !== 5'd8) begin errors++; $display("FAIL div_decode: got md=%b div=%b rd=%0d want 1 1 8", ex_md_op, ex_md_div, ex_rd); end
        for (int i = 1; i <= 40; i++) begin
            step();
            if (md_busy) busy_cnt++;
            if (if_ready) begin
                ready_at = i;
                break;
            end
        end
        checks++; if (ready_at !== 33) begin errors++; $display("FAIL div_ready_cycle: got %0d want 33", ready_at); end
        checks++; if (busy_cnt !== 32) begin errors++; $display("FAIL div_busy_cycles: got %0d want 32", busy_cnt); end
        step();
        if_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9) begin errors++; $display("FAIL div_next: got v=%b rd=%0d want v=1 rd=9", ex_valid, ex_rd); end
        step();
    endtask

    task automatic test_flush();
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = I_DIV8;
        step();
        if_valid = 1'b0;
        repeat (13) step();
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b want 1", md_busy); end
        flush = 1'b1; if_valid = 1'b1; if_instr = I_ADD9;
        #1;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got %b want 0", if_ready); end
        step();
        flush = 1'b0;
        #1;
        checks++; if (md_busy !== 1'b0 || ex_valid !== 1'b0 || if_ready !== 1'b1) begin errors++; $display("FAIL flush_cancel: got busy=%b v=%b rdy=%b want 0 0 1", md_busy, ex_valid, if_ready); end
        step();
        if_valid = 1'b0; ex_ready = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9) begin errors++; $display("FAIL flush_next: got v=%b rd=%0d want v=1 rd=9", ex_valid, ex_rd); end
        flush = 1'b1;
        step();
        flush = 1'b0; ex_ready = 1'b1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b want 0", ex_valid); end
    endtask

    task automatic test_reset_mid();
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = I_DIV8;
        step();
        if_valid = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        checks++; if (md_busy !== 1'b0 || ex_valid !== 1'b0 || if_ready !== 1'b0) begin errors++; $display("FAIL reset_mid: got busy=%b v=%b rdy=%b want 0 0 0", md_busy, ex_valid, if_ready); end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_back_to_back();
        test_load_use();
        test_stall();
        test_md_mul();
        test_md_div();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Registered RV32I/M decode-and-issue stage between fetch and execute in the pipelined core. Decodes the instruction accepted from IF into the core control bundle, holds it in the ID/EX register under a valid/ready handshake, inserts the load-use bubble, and blocks issue for the latency of M-extension multiply/divide operations. It supersedes purely combinational decode with decode plus hazard handling and back-pressure.

## Interface
- XLEN, 32: PC width.
- EN_M, 1: 1 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 flags them illegal.
- MUL_LAT, 2: extra issue-block cycles after a multiply leaves ID/EX (≥1).
- DIV_LAT, 32: extra issue-block cycles after a div/rem leaves ID/EX (≥1).
- CNT_W, 6: md counter width; must hold max(MUL_LAT, DIV_LAT).

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_valid / if_ready  in / out  1 / 1  IF→ID handshake.
- if_instr / if_pc  in  32 / XLEN  instruction and its PC.
- flush  in  1  kill ID/EX contents and cancel md blocking (from EX branch/jump redirect).
- ex_ready  in  1  EX accepts the ID/EX register this cycle.
- ex_valid  out  1  ID/EX holds an instruction.
- ex_pc  out  XLEN; ex_rs1, ex_rs2, ex_rd  out  5 each.
- ex_mem_read out 3; ex_mem_write out 2; ex_wb_sel out 2 (00 ALU, 01 mem, 10 PC+4).
- ex_alu_a_src, ex_alu_b_src  out  1 each; ex_imm_type out 3; ex_alu_code out 5; ex_branch_flag out 6 (one-hot BEQ,BNE,BLT,BGE,BLTU,BGEU at bits 0..5).
- ex_wb_en, ex_jump, ex_md_op, ex_md_div, ex_illegal  out  1 each.
- md_busy  out  1  md counter nonzero.

## Operation
- Decode as per Defines.vh codes: OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR; OP with funct7=0000001 and EN_M=1 → ex_md_op=1, ex_md_div=funct3[2], ex_wb_en=1, ex_alu_code=ALU_ADD.
- ex_alu_code is ALU_ADD for every instruction not assigning another code (no latch, no stale value).
- JAL/JALR set ex_jump=1. Branches set exactly one ex_branch_flag bit; reserved funct3 (010/011) is illegal.
- Illegal: unknown opcode, unlisted funct7/funct3 pair, reserved load/store funct3, M op with EN_M=0. Illegal instr is still issued with ex_illegal=1 and ex_wb_en=0, ex_mem_read=0, ex_mem_write=0, ex_jump=0, ex_branch_flag=0.
- rs uses: rs1 used by all except LUI/AUIPC/JAL; rs2 used by OP, STORE, BRANCH only.
- Load-use hazard: ex_valid & ex_mem_read≠0 & ex_rd≠0 & incoming used rs equals ex_rd.
- md counter: on ex_valid&ex_ready&ex_md_op, load DIV_LAT if ex_md_div else MUL_LAT; else decrement if nonzero.
- if_ready = rst_n & ~flush & ~hazard & ~md_busy & ~(ex_valid&ex_md_op) & (~ex_valid | ex_ready).
- ID/EX update priority: reset > flush (ex_valid←0, counter←0) > accept (load decoded bundle, ex_valid←1) > drain (ex_valid&ex_ready: ex_valid←0) > hold.

## Timing
- Reset: ex_valid=0, every ex_* field 0, counter 0, md_busy=0; if_ready=0 while rst_n=0.
- Latency: instruction accepted in cycle t appears with ex_valid=1 in t+1.
- Full throughput: back-to-back accepts when ex_ready=1 and no hazard.
- ex_* fields stable while ex_valid=1 & ex_ready=0.
- Load-use: exactly one bubble cycle (ex_valid=0) between the load and its consumer.
- M op handed off in t: if_ready=0 in t+1..t+LAT, earliest next accept t+LAT+1.
- flush in t: no accept in t, ex_valid=0 and md_busy=0 in t+1; flush coincident with ex_ready has no effect on EX's capture in t.
- Reset mid-stall or mid-md count returns to reset state next edge.

## Test plan
- Reset held 3 cycles with if_valid=1 → if_ready=0, all outputs 0; release, ADD x3,x1,x2 (0x002081B3) → next cycle ex_valid=1, ex_rd=3, ex_wb_en=1, ex_alu_code=ALU_ADD.
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x0 (0x00028333), ex_ready=1 → ex_mem_read=MEM_READ_WORD, one ex_valid=0 bubble, ADD issued the following cycle.
- MUL x7,x1,x2 (0x022083B3) followed by ADD, MUL_LAT=2 → md_busy=1 two cycles, ADD accepted 3 cycles after MUL handoff; DIV x8,x1,x2 (0x0220C433) → 32-cycle block.
- ex_ready=0 for 4 cycles with ADD in ID/EX → if_ready=0, fields unchanged; ex_ready=1 → next instr accepted same cycle.
- flush during DIV count (counter=20) → md_busy=0 and ex_valid=0 next cycle, if_ready=1 after.
- EN_M=0 instance fed 0x022083B3, and opcode 0x7F → ex_illegal=1, ex_wb_en=0, no mem enables.
